armleocpu_bus_arbiter: RTL and testbench

Two-master, one-slave arbiter that shares a single external memory port between the D-cache and I-cache backing-memory interfaces of the core. It sits between the two cache `m_*` ports and the SoC interconnect. It grants the bus per complete transaction, including bursts, with round-robin fairness. It routes `done`, `response` and `rdata` back only to the granted cache.

---
 rtl/armleocpu_bus_arbiter_pkg.sv | 55 +++++
 rtl/armleocpu_rr_arbiter2.sv | 28 ++
 rtl/armleocpu_bus_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_armleocpu_bus_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/armleocpu_bus_arbiter_pkg.sv
// armleocpu_bus_defs: bus definitions shared by the caches and the
// backing-memory arbiter.
//   - field widths of the cache <-> memory bus
//   - command and response codes
//   - port indices of the two-master arbiter
//   - arbiter FSM state type
//   - packed request/response payload structs
package armleocpu_bus_defs;

  localparam int unsigned CMD_W  = 3;
  localparam int unsigned RESP_W = 3;
  localparam int unsigned ADDR_W = 34;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  // Command codes
  localparam logic [CMD_W-1:0] CMD_NONE  = CMD_W'(0);
  localparam logic [CMD_W-1:0] CMD_READ  = CMD_W'(1);
  localparam logic [CMD_W-1:0] CMD_WRITE = CMD_W'(2);

  // Response codes; anything other than OKAY terminates a burst
  localparam logic [RESP_W-1:0] RESP_OKAY      = RESP_W'(0);
  localparam logic [RESP_W-1:0] RESP_SLAVEERR  = RESP_W'(1);
  localparam logic [RESP_W-1:0] RESP_DECODEERR = RESP_W'(2);

  // Arbiter port indices
  localparam logic PORT_D = 1'b0;
  localparam logic PORT_I = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  // Request payload (burstcount is parameterised and kept outside)
  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   wbyte_enable;
  } bus_req_t;

  // Per-beat completion payload
  typedef struct packed {
    logic              done;
    logic [RESP_W-1:0] response;
    logic [DATA_W-1:0] rdata;
  } bus_rsp_t;

  // True when a beat response must abort the rest of the burst
  function automatic logic resp_is_error(input logic [RESP_W-1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/armleocpu_rr_arbiter2.sv
// armleocpu_rr_arbiter2: combinational two-input round-robin pick.
// Ports:
//   req_i       in  2  request vector, bit 0 = D-cache, bit 1 = I-cache
//   last_i      in  1  port granted most recently
//   gnt_valid_o out 1  at least one request present
//   gnt_o       out 1  chosen port (valid only when gnt_valid_o)
module armleocpu_rr_arbiter2
  import armleocpu_bus_defs::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       gnt_valid_o,
  output logic       gnt_o
);

  // On a tie the port that was not served last wins
  always_comb begin
    gnt_valid_o = |req_i;
    gnt_o       = PORT_D;
    case (req_i)
      2'b01:   gnt_o = PORT_D;
      2'b10:   gnt_o = PORT_I;
      2'b11:   gnt_o = ~last_i;
      default: gnt_o = PORT_D;
    endcase
  end

endmodule

// File: rtl/armleocpu_bus_arbiter.sv
// armleocpu_bus_arbiter: shares one backing-memory port between the
// D-cache (port 0) and I-cache (port 1). The bus is held for a complete
// transaction (all burst beats), grants alternate on contention, and
// completions are routed combinationally to the granted cache only.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   d_*/i_* transaction, cmd, address,
//     burstcount, wdata, wbyte_enable  upstream requests (inputs)
//   d_*/i_* transaction_done,
//     transaction_response, rdata      upstream completions (outputs)
//   m_transaction .. m_wbyte_enable    downstream request (outputs)
//   m_transaction_done, m_transaction_response, m_rdata
//                                      downstream completion (inputs)
module armleocpu_bus_arbiter
  import armleocpu_bus_defs::*;
#(
  parameter int unsigned BURST_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic                d_transaction,
  input  logic [CMD_W-1:0]    d_cmd,
  input  logic [ADDR_W-1:0]   d_address,
  input  logic [BURST_W-1:0]  d_burstcount,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [BE_W-1:0]     d_wbyte_enable,
  output logic                d_transaction_done,
  output logic [RESP_W-1:0]   d_transaction_response,
  output logic [DATA_W-1:0]   d_rdata,

  input  logic                i_transaction,
  input  logic [CMD_W-1:0]    i_cmd,
  input  logic [ADDR_W-1:0]   i_address,
  input  logic [BURST_W-1:0]  i_burstcount,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [BE_W-1:0]     i_wbyte_enable,
  output logic                i_transaction_done,
  output logic [RESP_W-1:0]   i_transaction_response,
  output logic [DATA_W-1:0]   i_rdata,

  output logic                m_transaction,
  output logic [CMD_W-1:0]    m_cmd,
  output logic [ADDR_W-1:0]   m_address,
  output logic [BURST_W-1:0]  m_burstcount,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [BE_W-1:0]     m_wbyte_enable,
  input  logic                m_transaction_done,
  input  logic [RESP_W-1:0]   m_transaction_response,
  input  logic [DATA_W-1:0]   m_rdata
);

  arb_state_t           state_q, state_d;
  logic                 grant_q, grant_d;
  logic                 last_q, last_d;
  logic [BURST_W-1:0]   beat_cnt_q, beat_cnt_d;

  logic                 rr_valid;
  logic                 rr_gnt;

  bus_req_t             sel_req;
  logic                 sel_trans;
  logic [BURST_W-1:0]   sel_burst;
  logic [BURST_W-1:0]   last_beat;
  logic                 final_beat;
  bus_rsp_t             m_rsp;

  armleocpu_rr_arbiter2 u_rr (
    .req_i       ({i_transaction, d_transaction}),
    .last_i      (last_q),
    .gnt_valid_o (rr_valid),
    .gnt_o       (rr_gnt)
  );

  // Request fields of the currently granted port
  always_comb begin
    if (grant_q == PORT_I) begin
      sel_trans            = i_transaction;
      sel_burst            = i_burstcount;
      sel_req.cmd          = i_cmd;
      sel_req.address      = i_address;
      sel_req.wdata        = i_wdata;
      sel_req.wbyte_enable = i_wbyte_enable;
    end else begin
      sel_trans            = d_transaction;
      sel_burst            = d_burstcount;
      sel_req.cmd          = d_cmd;
      sel_req.address      = d_address;
      sel_req.wdata        = d_wdata;
      sel_req.wbyte_enable = d_wbyte_enable;
    end
  end

  assign m_rsp.done     = m_transaction_done;
  assign m_rsp.response = m_transaction_response;
  assign m_rsp.rdata    = m_rdata;

  // Burstcount 0 behaves as a single beat; an error response ends early
  assign last_beat  = (sel_burst == '0) ? '0 : sel_burst - BURST_W'(1);
  assign final_beat = m_rsp.done &&
                      ((beat_cnt_q == last_beat) || resp_is_error(m_rsp.response));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= PORT_D;
      last_q     <= PORT_I;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Next-state and outputs; IDLE drives every output to zero
  always_comb begin
    state_d                = state_q;
    grant_d                = grant_q;
    last_d                 = last_q;
    beat_cnt_d             = beat_cnt_q;

    m_transaction          = 1'b0;
    m_cmd                  = '0;
    m_address              = '0;
    m_burstcount           = '0;
    m_wdata                = '0;
    m_wbyte_enable         = '0;
    d_transaction_done     = 1'b0;
    d_transaction_response = '0;
    d_rdata                = '0;
    i_transaction_done     = 1'b0;
    i_transaction_response = '0;
    i_rdata                = '0;

    case (state_q)
      ST_IDLE: begin
        if (rr_valid) begin
          grant_d    = rr_gnt;
          beat_cnt_d = '0;
          state_d    = ST_BUSY;
        end
      end

      ST_BUSY: begin
        m_transaction  = sel_trans;
        m_cmd          = sel_req.cmd;
        m_address      = sel_req.address;
        m_burstcount   = sel_burst;
        m_wdata        = sel_req.wdata;
        m_wbyte_enable = sel_req.wbyte_enable;

        if (grant_q == PORT_I) begin
          i_transaction_done     = m_rsp.done;
          i_transaction_response = m_rsp.response;
          i_rdata                = m_rsp.rdata;
        end else begin
          d_transaction_done     = m_rsp.done;
          d_transaction_response = m_rsp.response;
          d_rdata                = m_rsp.rdata;
        end

        if (m_rsp.done) begin
          beat_cnt_d = beat_cnt_q + BURST_W'(1);
        end
        // Stay BUSY until the downstream finishes, even if the request drops
        if (final_beat) begin
          last_d     = grant_q;
          beat_cnt_d = '0;
          state_d    = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_armleocpu_bus_arbiter.sv
// Directed self-checking bench for armleocpu_bus_arbiter. Inputs change at
// posedge+1, outputs are compared at posedge+2.
module tb_armleocpu_bus_arbiter;
  import armleocpu_bus_defs::*;

  localparam int unsigned BW = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              d_transaction, i_transaction;
  logic [CMD_W-1:0]  d_cmd, i_cmd;
  logic [ADDR_W-1:0] d_address, i_address;
  logic [BW-1:0]     d_burstcount, i_burstcount;
  logic [DATA_W-1:0] d_wdata, i_wdata;
  logic [BE_W-1:0]   d_wbyte_enable, i_wbyte_enable;
  logic              d_transaction_done, i_transaction_done;
  logic [RESP_W-1:0] d_transaction_response, i_transaction_response;
  logic [DATA_W-1:0] d_rdata, i_rdata;
  logic              m_transaction;
  logic [CMD_W-1:0]  m_cmd;
  logic [ADDR_W-1:0] m_address;
  logic [BW-1:0]     m_burstcount;
  logic [DATA_W-1:0] m_wdata;
  logic [BE_W-1:0]   m_wbyte_enable;
  logic              m_transaction_done;
  logic [RESP_W-1:0] m_transaction_response;
  logic [DATA_W-1:0] m_rdata;

  int checks = 0;
  int errors = 0;

  armleocpu_bus_arbiter #(.BURST_W(BW)) dut (
    .clk(clk), .rst_n(rst_n),
    .d_transaction(d_transaction), .d_cmd(d_cmd), .d_address(d_address),
    .d_burstcount(d_burstcount), .d_wdata(d_wdata), .d_wbyte_enable(d_wbyte_enable),
    .d_transaction_done(d_transaction_done), .d_transaction_response(d_transaction_response),
    .d_rdata(d_rdata),
    .i_transaction(i_transaction), .i_cmd(i_cmd), .i_address(i_address),
    .i_burstcount(i_burstcount), .i_wdata(i_wdata), .i_wbyte_enable(i_wbyte_enable),
    .i_transaction_done(i_transaction_done), .i_transaction_response(i_transaction_response),
    .i_rdata(i_rdata),
    .m_transaction(m_transaction), .m_cmd(m_cmd), .m_address(m_address),
    .m_burstcount(m_burstcount), .m_wdata(m_wdata), .m_wbyte_enable(m_wbyte_enable),
    .m_transaction_done(m_transaction_done), .m_transaction_response(m_transaction_response),
    .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  // A granted cache must keep its request up until its final done
  always @(negedge clk) begin
    if (rst_n) begin
      assert (!(d_transaction_done && !d_transaction))
        else $error("FAIL d_request_held: D dropped its request while granted");
      assert (!(i_transaction_done && !i_transaction))
        else $error("FAIL i_request_held: I dropped its request while granted");
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    d_transaction = 0; d_cmd = '0; d_address = '0; d_burstcount = '0;
    d_wdata = '0; d_wbyte_enable = '0;
    i_transaction = 0; i_cmd = '0; i_address = '0; i_burstcount = '0;
    i_wdata = '0; i_wbyte_enable = '0;
    m_transaction_done = 0; m_transaction_response = '0; m_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    clear_inputs();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 0;
    d_transaction = 1; d_address = 34'h0_0000_0100; d_burstcount = 4'd1; d_cmd = CMD_READ;
    i_transaction = 1; i_address = 34'h0_0000_0200; i_burstcount = 4'd1; i_cmd = CMD_READ;
    m_transaction_done = 1; m_rdata = 32'hA5A5_A5A5;
    cyc(); cyc(); #1;
    checks++; if (m_transaction !== 1'b0) begin errors++; $display("FAIL reset_m_transaction: got %0h expected 0", m_transaction); end
    checks++; if (m_address !== 34'h0) begin errors++; $display("FAIL reset_m_address: got %0h expected 0", m_address); end
    checks++; if (d_transaction_done !== 1'b0) begin errors++; $display("FAIL reset_d_done: got %0h expected 0", d_transaction_done); end
    checks++; if (i_transaction_done !== 1'b0) begin errors++; $display("FAIL reset_i_done: got %0h expected 0", i_transaction_done); end
    checks++; if (d_rdata !== 32'h0) begin errors++; $display("FAIL reset_d_rdata: got %0h expected 0", d_rdata); end
    @(negedge clk);
    rst_n = 1;
    m_transaction_done = 0;
    cyc(); #1;
    checks++; if (m_transaction !== 1'b1) begin errors++; $display("FAIL reset_first_grant_valid: got %0h expected 1", m_transaction); end
    checks++; if (m_address !== 34'h0_0000_0100) begin errors++; $display("FAIL reset_first_grant_d: got %0h expected 100", m_address); end
    m_transaction_done = 1; m_rdata = 32'h1234_5678;
    #1;
    checks++; if (d_transaction_done !== 1'b1) begin errors++; $display("FAIL reset_d_done_routed: got %0h expected 1", d_transaction_done); end
    checks++; if (i_transaction_done !== 1'b0) begin errors++; $display("FAIL reset_i_done_blocked: got %0h expected 0", i_transaction_done); end
    cyc();
    m_transaction_done = 0; d_transaction = 0;
    #1;
    checks++; if (m_transaction !== 1'b0) begin errors++; $display("FAIL reset_idle_gap: got %0h expected 0", m_transaction); end
  endtask

  task automatic test_single_read();
    do_reset();
    d_transaction = 1; d_cmd = CMD_READ; d_address = 34'h0_0000_1000; d_burstcount = 4'd1;
    cyc(); #1;
    checks++; if (m_address !== 34'h0_0000_1000) begin errors++; $display("FAIL read_m_address: got %0h expected 1000", m_address); end
    checks++; if (m_cmd !== CMD_READ) begin errors++; $display("FAIL read_m_cmd: got %0h expected %0h", m_cmd, CMD_READ); end
    checks++; if (m_burstcount !== 4'd1) begin errors++; $display("FAIL read_m_burstcount: got %0h expected 1", m_burstcount); end
    m_transaction_done = 1; m_transaction_response = RESP_OKAY; m_rdata = 32'hDEADBEEF;
    #1;
    checks++; if (d_transaction_done !== 1'b1) begin errors++; $display("FAIL read_d_done: got %0h expected 1", d_transaction_done); end
    checks++; if (d_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL read_d_rdata: got %0h expected deadbeef", d_rdata); end
    checks++; if (i_transaction_done !== 1'b0) begin errors++; $display("FAIL read_i_done: got %0h expected 0", i_transaction_done); end
    checks++; if (i_rdata !== 32'h0) begin errors++; $display("FAIL read_i_rdata: got %0h expected 0", i_rdata); end
    cyc();
    m_transaction_done = 0; d_transaction = 0;
    #1;
    checks++; if (m_transaction !== 1'b0) begin errors++; $display("FAIL read_back_to_idle: got %0h expected 0", m_transaction); end
    // Burstcount 0 completes after one beat
    d_transaction = 1; d_cmd = CMD_WRITE; d_address = 34'h0_0000_2000; d_burstcount = 4'd0;
    d_wdata = 32'hCAFE_F00D; d_wbyte_enable = 4'hF;
    cyc(); #1;
    checks++; if (m_wdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL bc0_m_wdata: got %0h expected cafef00d", m_wdata); end
    m_transaction_done = 1;
    cyc();
    m_transaction_done = 0; d_transaction = 0;
    #1;
    checks++; if (m_transaction !== 1'b0) begin errors++; $display("FAIL bc0_single_beat: got %0h expected 0", m_transaction); end
  endtask

  task automatic test_burst();
    do_reset();
    i_transaction = 1; i_cmd = CMD_READ; i_address = 34'h1_0000_0000; i_burstcount = 4'd8;
    d_cmd = CMD_WRITE; d_address = 34'h0_0000_3000; d_burstcount = 4'd1;
    cyc();
    for (int b = 0; b < 8; b++) begin
      i_address = 34'h1_0000_0000 + 34'(b * 4);
      if (b == 2) d_transaction = 1;
      m_transaction_done = 1; m_rdata = 32'(b);
      #1;
      checks++; if (m_address !== 34'h1_0000_0000 + 34'(b * 4)) begin errors++; $display("FAIL burst_addr_beat%0d: got %0h expected %0h", b, m_address, 34'h1_0000_0000 + 34'(b * 4)); end
      checks++; if (i_transaction_done !== 1'b1 || d_transaction_done !== 1'b0) begin errors++; $display("FAIL burst_done_beat%0d: got i=%0h d=%0h expected i=1 d=0", b, i_transaction_done, d_transaction_done); end
      cyc();
    end
    m_transaction_done = 0; i_transaction = 0;
    #1;
    checks++; if (m_transaction !== 1'b0) begin errors++; $display("FAIL burst_idle_gap: got %0h expected 0", m_transaction); end
    cyc(); #1;
    checks++; if (m_transaction !== 1'b1 || m_address !== 34'h0_0000_3000) begin errors++; $display("FAIL burst_d_granted_next: got t=%0h a=%0h expected t=1 a=3000", m_transaction, m_address); end
    m_transaction_done = 1;
    cyc();
    m_transaction_done = 0; d_transaction = 0;
  endtask

  task automatic test_round_robin();
    logic exp_port;
    do_reset();
    d_transaction = 1; d_address = 34'h0_0000_D000; d_burstcount = 4'd1;
    i_transaction = 1; i_address = 34'h0_0000_E000; i_burstcount = 4'd1;
    for (int t = 0; t < 8; t++) begin
      exp_port = (t % 2 == 1) ? PORT_I : PORT_D;
      cyc(); #1;
      checks++; if (m_address !== (exp_port ? 34'h0_0000_E000 : 34'h0_0000_D000)) begin errors++; $display("FAIL rr_grant_%0d: got %0h expected port %0d", t, m_address, exp_port); end
      m_transaction_done = 1;
      #1;
      checks++; if ({i_transaction_done, d_transaction_done} !== (exp_port ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_done_%0d: got i=%0h d=%0h expected port %0d", t, i_transaction_done, d_transaction_done, exp_port); end
      cyc();
      m_transaction_done = 0;
    end
    d_transaction = 0; i_transaction = 0;
  endtask

  task automatic test_error_abort();
    do_reset();
    d_transaction = 1; d_cmd = CMD_READ; d_address = 34'h0_0000_4000; d_burstcount = 4'd4;
    i_address = 34'h0_0000_5000; i_burstcount = 4'd1;
    cyc();
    i_transaction = 1;
    m_transaction_done = 1; m_transaction_response = RESP_OKAY;
    cyc();
    m_transaction_response = RESP_SLAVEERR;
    #1;
    checks++; if (d_transaction_done !== 1'b1 || d_transaction_response !== RESP_SLAVEERR) begin errors++; $display("FAIL abort_err_beat: got done=%0h resp=%0h expected done=1 resp=%0h", d_transaction_done, d_transaction_response, RESP_SLAVEERR); end
    checks++; if (i_transaction_response !== '0) begin errors++; $display("FAIL abort_i_resp: got %0h expected 0", i_transaction_response); end
    cyc();
    m_transaction_done = 0; m_transaction_response = RESP_OKAY; d_transaction = 0;
    #1;
    checks++; if (m_transaction !== 1'b0) begin errors++; $display("FAIL abort_idle: got %0h expected 0", m_transaction); end
    cyc(); #1;
    checks++; if (m_transaction !== 1'b1 || m_address !== 34'h0_0000_5000) begin errors++; $display("FAIL abort_i_granted: got t=%0h a=%0h expected t=1 a=5000", m_transaction, m_address); end
    m_transaction_done = 1;
    cyc();
    m_transaction_done = 0; i_transaction = 0;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    d_transaction = 1; d_address = 34'h0_0000_6000; d_burstcount = 4'd8;
    cyc();
    m_transaction_done = 1;
    cyc(); cyc();
    #1;
    rst_n = 0;
    #1;
    checks++; if (m_transaction !== 1'b0 || m_address !== 34'h0) begin errors++; $display("FAIL midrst_outputs: got t=%0h a=%0h expected 0 0", m_transaction, m_address); end
    checks++; if (d_transaction_done !== 1'b0) begin errors++; $display("FAIL midrst_d_done: got %0h expected 0", d_transaction_done); end
    d_transaction = 0; m_transaction_done = 0;
    i_transaction = 1; i_address = 34'h0_0000_7000; i_burstcount = 4'd2;
    @(negedge clk);
    rst_n = 1;
    cyc(); #1;
    checks++; if (m_transaction !== 1'b1 || m_address !== 34'h0_0000_7000) begin errors++; $display("FAIL midrst_i_granted: got t=%0h a=%0h expected t=1 a=7000", m_transaction, m_address); end
    m_transaction_done = 1;
    cyc();
    m_transaction_done = 0;
    #1;
    checks++; if (m_transaction !== 1'b1) begin errors++; $display("FAIL midrst_beat_cnt_restart: got %0h expected 1", m_transaction); end
    m_transaction_done = 1;
    cyc();
    m_transaction_done = 0; i_transaction = 0;
    #1;
    checks++; if (m_transaction !== 1'b0) begin errors++; $display("FAIL midrst_second_beat_ends: got %0h expected 0", m_transaction); end
  endtask

  initial begin
    rst_n = 0;
    clear_inputs();
    test_reset();
    test_single_read();
    test_burst();
    test_round_robin();
    test_error_abort();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
